// File: rtl/window_assembler_pkg.sv
// Shared constants for the window assembler and the address generator.
package window_assembler_pkg;

  // Default window edge: odd and at least 3.
  localparam int unsigned FilterSizeDefault = 5;

  // One-hot controller states.
  typedef enum logic [3:0] {
    StIdle = 4'b0001,
    StFill = 4'b0010,
    StRun  = 4'b0100,
    StDone = 4'b1000
  } state_e;

endpackage

// File: rtl/pixel_column_shifter.sv
// Captures one window column of filterSize pixels, top to bottom; padded pixels are stored as zero.
module pixel_column_shifter #(
  parameter int unsigned pixelBitWidth = 8,
  parameter int unsigned filterSize    = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear,
  input  logic                                accept,
  input  logic [pixelBitWidth-1:0]            pix_data,
  input  logic                                pix_pad,
  output logic                                col_done,
  output logic [filterSize*pixelBitWidth-1:0] col_data
);

  localparam int unsigned ColW = filterSize * pixelBitWidth;
  localparam int unsigned CntW = $clog2(filterSize);

  logic [CntW-1:0]          pix_cnt;
  logic [ColW-1:0]          col_q;
  logic [pixelBitWidth-1:0] pix_in;

  // New pixel enters at the top slot so the first pixel of a column ends up at row 0.
  always_comb begin
    pix_in   = pix_pad ? '0 : pix_data;
    col_done = accept && (pix_cnt == CntW'(filterSize - 1));
    col_data = {pix_in, col_q[ColW-1:pixelBitWidth]};
  end

  // Shift register and pixel-in-column counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt <= '0;
      col_q   <= '0;
    end else if (clear) begin
      pix_cnt <= '0;
    end else if (accept) begin
      col_q   <= col_data;
      pix_cnt <= col_done ? '0 : pix_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/window_assembler.sv
// Assembles filterSize x filterSize windows from a column-ordered pixel stream.
module window_assembler import window_assembler_pkg::*; #(
  parameter int unsigned pixelBitWidth = 8,
  parameter int unsigned filterSize    = FilterSizeDefault,
  parameter int unsigned rowBitWidth   = 11,
  parameter int unsigned colBitWidth   = 11
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic [rowBitWidth-1:0]                         rowMax,
  input  logic [colBitWidth-1:0]                         colMax,
  input  logic                                           pix_valid,
  input  logic [pixelBitWidth-1:0]                       pix_data,
  input  logic                                           pix_pad,
  output logic                                           in_ready,
  output logic                                           win_valid,
  input  logic                                           win_ready,
  output logic [filterSize*filterSize*pixelBitWidth-1:0] window,
  output logic [rowBitWidth-1:0]                         win_row,
  output logic [colBitWidth-1:0]                         win_col,
  output logic                                           frame_done
);

  localparam int unsigned ColW = filterSize * pixelBitWidth;
  localparam int unsigned WinW = filterSize * ColW;
  // Column counter must reach colMax+filterSize-2, which can exceed colBitWidth.
  localparam int unsigned CntW = colBitWidth + 1;

  state_e                 state;
  logic [rowBitWidth-1:0] row_max_q;
  logic [colBitWidth-1:0] col_max_q;
  logic [rowBitWidth-1:0] row_cnt;
  logic [CntW-1:0]        col_cnt;
  logic [CntW-1:0]        col_last;
  // Set once the final column of the frame is in; blocks further input.
  logic                   tail_q;
  logic                   accept;
  logic                   clear;
  logic                   col_done;
  logic [ColW-1:0]        col_data;
  logic                   win_take;
  logic                   last_win;

  // Input handshake and end-of-row / end-of-frame decodes.
  always_comb begin
    in_ready = ((state == StFill) || (state == StRun)) && !tail_q && !(win_valid && !win_ready);
    accept   = pix_valid && in_ready;
    clear    = (state == StIdle) && start;
    col_last = CntW'(col_max_q) + CntW'(filterSize - 2);
    win_take = win_valid && win_ready;
    last_win = (win_row == rowBitWidth'(row_max_q - rowBitWidth'(1))) &&
               (win_col == colBitWidth'(col_max_q - colBitWidth'(1)));
  end

  pixel_column_shifter #(
    .pixelBitWidth(pixelBitWidth),
    .filterSize   (filterSize)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .accept   (accept),
    .pix_data (pix_data),
    .pix_pad  (pix_pad),
    .col_done (col_done),
    .col_data (col_data)
  );

  // Controller FSM with registered window outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      row_max_q  <= '0;
      col_max_q  <= '0;
      row_cnt    <= '0;
      col_cnt    <= '0;
      tail_q     <= 1'b0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      window     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (win_take) win_valid <= 1'b0;
      // Oldest column drops out at c=0, new column lands at c=filterSize-1.
      if (col_done) window <= {col_data, window[WinW-1:ColW]};
      unique case (state)
        StIdle: begin
          if (start) begin
            row_max_q <= rowMax;
            col_max_q <= colMax;
            row_cnt   <= '0;
            col_cnt   <= '0;
            tail_q    <= 1'b0;
            state     <= StFill;
          end
        end
        StFill: begin
          if (col_done) begin
            col_cnt <= col_cnt + CntW'(1);
            if (col_cnt == CntW'(filterSize - 2)) state <= StRun;
          end
        end
        StRun: begin
          if (col_done) begin
            win_valid <= 1'b1;
            win_row   <= row_cnt;
            win_col   <= colBitWidth'(col_cnt - CntW'(filterSize - 1));
            if (col_cnt == col_last) begin
              col_cnt <= '0;
              if (row_cnt == rowBitWidth'(row_max_q - rowBitWidth'(1))) begin
                tail_q <= 1'b1;
              end else begin
                row_cnt <= row_cnt + rowBitWidth'(1);
                state   <= StFill;
              end
            end else begin
              col_cnt <= col_cnt + CntW'(1);
            end
          end
          if (win_take && last_win) begin
            state      <= StDone;
            frame_done <= 1'b1;
          end
        end
        StDone: begin
          if (start) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_window_assembler.sv
// Directed bench for window_assembler: 5x5 windows over a 4x6 frame with padded borders.
module tb_window_assembler;

  localparam int W    = 8;
  localparam int F    = 5;
  localparam int RB   = 11;
  localparam int CB   = 11;
  localparam int ROWS = 4;
  localparam int COLS = 6;
  localparam int CPR  = COLS + F - 1;
  localparam int NPIX = ROWS * CPR * F;
  localparam int NWIN = ROWS * COLS;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [RB-1:0]    rowMax;
  logic [CB-1:0]    colMax;
  logic             pix_valid;
  logic [W-1:0]     pix_data;
  logic             pix_pad;
  logic             in_ready;
  logic             win_valid;
  logic             win_ready;
  logic [F*F*W-1:0] window;
  logic [RB-1:0]    win_row;
  logic [CB-1:0]    win_col;
  logic             frame_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  window_assembler #(
    .pixelBitWidth(W),
    .filterSize   (F),
    .rowBitWidth  (RB),
    .colBitWidth  (CB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rowMax    (rowMax),
    .colMax    (colMax),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_pad   (pix_pad),
    .in_ready  (in_ready),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .window    (window),
    .win_row   (win_row),
    .win_col   (win_col),
    .frame_done(frame_done)
  );

  // Frame pixel value, or -1 outside the frame.
  function automatic int frame_pix(input int y, input int x);
    if (y < 0 || y >= ROWS || x < 0 || x >= COLS) return -1;
    return y * 16 + x + 1;
  endfunction

  function automatic logic [F*F*W-1:0] exp_window(input int r, input int c);
    logic [F*F*W-1:0] w;
    int v;
    w = '0;
    for (int ec = 0; ec < F; ec++) begin
      for (int er = 0; er < F; er++) begin
        v = frame_pix(r - F / 2 + er, c - F / 2 + ec);
        if (v >= 0) w[(ec * F + er) * W +: W] = W'(v);
      end
    end
    return w;
  endfunction

  // Stream pixel p: columns of F pixels, CPR columns per output row.
  task automatic stream_pixel(input int p, output logic [W-1:0] d, output logic pad);
    int k, r, j, er, v;
    k   = p / F;
    r   = k / CPR;
    j   = k % CPR;
    er  = p % F;
    v   = frame_pix(r - F / 2 + er, j - F / 2);
    pad = (v < 0);
    d   = pad ? 8'hFF : W'(v);
  endtask

  task automatic pulse_start();
    start  = 1'b1;
    rowMax = RB'(ROWS);
    colMax = CB'(COLS);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs one frame from IDLE. abort_after>=0 stops feeding after that many pixels.
  task automatic run_frame(input string tag, input bit gaps, input int stall_idx,
                           input int abort_after, input bit check_spacing);
    int  p = 0, nwin = 0, ndone = 0, ncyc = 0, post = 0, stall_cnt = 0, drops = 0;
    int  last_acc = 0;
    bit  acc;
    pulse_start();
    while (ncyc < 5000) begin
      if (abort_after >= 0 && p == abort_after) begin
        pix_valid = 1'b0;
        return;
      end
      if (p < NPIX && !(gaps && $urandom_range(0, 3) == 0)) begin
        pix_valid = 1'b1;
        stream_pixel(p, pix_data, pix_pad);
      end else begin
        pix_valid = 1'b0;
        pix_pad   = 1'b0;
      end
      if (win_valid && nwin == stall_idx && stall_cnt < 10) begin
        win_ready = 1'b0;
        stall_cnt++;
      end else begin
        win_ready = 1'b1;
      end
      @(negedge clk);
      acc = pix_valid && in_ready;
      if (pix_valid && !in_ready) drops++;
      if (frame_done) ndone++;
      if (win_valid && !win_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s stall_in_ready got %0b want 0", tag, in_ready);
        end
        checks++;
        if (window !== exp_window(nwin / COLS, nwin % COLS)) begin
          errors++;
          $display("FAIL %s stall_window got %h want %h", tag, window,
                   exp_window(nwin / COLS, nwin % COLS));
        end
      end
      if (win_valid && win_ready) begin
        checks++;
        if (win_row !== RB'(nwin / COLS) || win_col !== CB'(nwin % COLS)) begin
          errors++;
          $display("FAIL %s win%0d_coord got (%0d,%0d) want (%0d,%0d)", tag, nwin, win_row,
                   win_col, nwin / COLS, nwin % COLS);
        end
        checks++;
        if (window !== exp_window(nwin / COLS, nwin % COLS)) begin
          errors++;
          $display("FAIL %s win%0d_data got %h want %h", tag, nwin, window,
                   exp_window(nwin / COLS, nwin % COLS));
        end
        if (nwin == 0) begin
          checks++;
          if (window[(2 * F + 2) * W +: W] !== W'(frame_pix(0, 0))) begin
            errors++;
            $display("FAIL %s centre00 got %0d want %0d", tag, window[(2 * F + 2) * W +: W],
                     frame_pix(0, 0));
          end
        end
        if (check_spacing && (nwin % COLS) != 0) begin
          checks++;
          if (ncyc - last_acc != F) begin
            errors++;
            $display("FAIL %s spacing%0d got %0d want %0d", tag, nwin, ncyc - last_acc, F);
          end
        end
        last_acc = ncyc;
        nwin++;
      end
      @(posedge clk); #1;
      if (acc) p++;
      ncyc++;
      if (ndone > 0) post++;
      if (post == 4) break;
    end
    pix_valid = 1'b0;
    win_ready = 1'b1;
    checks++;
    if (nwin != NWIN) begin
      errors++;
      $display("FAIL %s window_count got %0d want %0d", tag, nwin, NWIN);
    end
    checks++;
    if (p != NPIX) begin
      errors++;
      $display("FAIL %s columns got %0d want %0d", tag, p / F, NPIX / F);
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL %s frame_done_pulses got %0d want 1", tag, ndone);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s done_in_ready got %0b want 0", tag, in_ready);
    end
    if (check_spacing) begin
      checks++;
      if (drops != 0) begin
        errors++;
        $display("FAIL %s input_stalls got %0d want 0", tag, drops);
      end
    end
  endtask

  // DONE -> IDLE on start; input stays closed.
  task automatic return_idle(input string tag);
    pulse_start();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || win_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s idle got in_ready=%0b win_valid=%0b want 0,0", tag, in_ready, win_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (win_valid !== 1'b0 || in_ready !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got v=%0b r=%0b d=%0b want 0,0,0", win_valid, in_ready,
               frame_done);
    end
    checks++;
    if (window !== '0 || win_row !== '0 || win_col !== '0) begin
      errors++;
      $display("FAIL reset_data got %h row %0d col %0d want 0", window, win_row, win_col);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stream_stall();
    run_frame("stream_stall", 1'b0, 2, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_frame("back_to_back", 1'b0, -1, -1, 1'b1);
  endtask

  task automatic test_abort();
    run_frame("abort", 1'b0, -1, 17, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (win_valid !== 1'b0 || in_ready !== 1'b0 || window !== '0) begin
        errors++;
        $display("FAIL abort_quiet got v=%0b r=%0b win=%h want 0,0,0", win_valid, in_ready,
                 window);
      end
    end
    @(posedge clk); #1;
    run_frame("after_abort", 1'b0, -1, -1, 1'b1);
  endtask

  task automatic test_gaps();
    run_frame("gaps", 1'b1, -1, -1, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    rowMax    = '0;
    colMax    = '0;
    pix_valid = 1'b0;
    pix_data  = '0;
    pix_pad   = 1'b0;
    win_ready = 1'b1;
    test_reset();
    test_stream_stall();
    return_idle("post_stream");
    test_back_to_back();
    return_idle("post_b2b");
    test_abort();
    return_idle("post_abort");
    test_gaps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
